// File: rtl/uart_cmd_pkg.sv
// Shared types, ASCII codes and hex helpers for the UART GPIO command sequencer.
// Pure declarations: no state, no latency, no flow control.
package uart_cmd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD_HI,
      CMD_LO,
      WAIT_CR,
      RESP0,
      RESP1,
      ERR,
      ECHO
   } state_t;

   typedef enum logic [1:0] {
      OP_W,
      OP_S,
      OP_C,
      OP_R
   } op_t;

   localparam logic [7:0] CH_W   = 8'h57;
   localparam logic [7:0] CH_S   = 8'h53;
   localparam logic [7:0] CH_C   = 8'h43;
   localparam logic [7:0] CH_R   = 8'h52;
   localparam logic [7:0] CH_CR  = 8'h0D;
   localparam logic [7:0] CH_LF  = 8'h0A;
   localparam logic [7:0] CH_K   = 8'h4B;
   localparam logic [7:0] CH_ERR = 8'h3F;

   function automatic logic is_hex(input logic [7:0] b);
      return ((b >= 8'h30) && (b <= 8'h39)) ||
             ((b >= 8'h41) && (b <= 8'h46)) ||
             ((b >= 8'h61) && (b <= 8'h66));
   endfunction

   // Only meaningful when is_hex(b) holds.
   function automatic logic [3:0] hex2nib(input logic [7:0] b);
      logic [7:0] v;
      if (b <= 8'h39)
         v = b - 8'h30;
      else if (b <= 8'h46)
         v = b - 8'h37;
      else
         v = b - 8'h57;
      return v[3:0];
   endfunction

   function automatic logic [7:0] nib2hex(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
   endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte watchdog: counts while enabled, pulses timeout at TIMEOUT_CYCLES-1.
// Combinational pulse, clear or disable returns the count to zero; no backpressure.
module uart_cmd_timeout #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic timeout
);
   localparam int TO_W = $clog2(TIMEOUT_CYCLES);

   logic [TO_W-1:0] cnt;

   assign timeout = en && !clr && (cnt == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clr || !en || timeout)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/uart_gpio_cmd_ctrl.sv
// ASCII W/S/C/R command sequencer on a UART byte stream driving gpio_out; gpio updates on the CR edge, reply valid next cycle.
// RX is stalled while any TX byte is pending; optional byte echo via UART_CMD_ECHO_EN.
module uart_gpio_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter logic [7:0] GPIO_RESET     = 8'h00,
   parameter int         TIMEOUT_CYCLES = 1000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       rx_ready,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic [7:0] gpio_out,
   output logic       busy,
   output logic [7:0] err_count
);
   state_t     state, state_next, parse_next;
   op_t        op;
   logic [7:0] operand;
   logic       rdy_en, accept, ignored, cnt_en, timeout;

   assign accept  = rx_valid && rx_ready;
   assign ignored = (state == IDLE) && ((rx_data == CH_CR) || (rx_data == CH_LF));
   assign cnt_en  = (state == CMD_HI) || (state == CMD_LO) || (state == WAIT_CR);

   uart_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clock   (clock),
      .reset   (reset),
      .clr     (accept),
      .en      (cnt_en),
      .timeout (timeout)
   );

`ifdef UART_CMD_ECHO_EN
   // The parse outcome is decided at acceptance and replayed after the echo drains.
   logic [7:0] echo_byte;
   state_t     echo_ret;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         echo_byte <= 8'h00;
         echo_ret  <= IDLE;
      end else if (accept && !ignored) begin
         echo_byte <= rx_data;
         echo_ret  <= parse_next;
      end
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      parse_next = state;
      case (state)
         IDLE: begin
            if (accept && !ignored) begin
               if ((rx_data == CH_W) || (rx_data == CH_S) || (rx_data == CH_C))
                  parse_next = CMD_HI;
               else if (rx_data == CH_R)
                  parse_next = WAIT_CR;
               else
                  parse_next = ERR;
            end
         end
         CMD_HI: begin
            if (accept)
               parse_next = is_hex(rx_data) ? CMD_LO : ERR;
            else if (timeout)
               parse_next = ERR;
         end
         CMD_LO: begin
            if (accept)
               parse_next = is_hex(rx_data) ? WAIT_CR : ERR;
            else if (timeout)
               parse_next = ERR;
         end
         WAIT_CR: begin
            if (accept)
               parse_next = (rx_data == CH_CR) ? RESP0 : ERR;
            else if (timeout)
               parse_next = ERR;
         end
         RESP0:   if (tx_ready) parse_next = (op == OP_R) ? RESP1 : IDLE;
         RESP1:   if (tx_ready) parse_next = IDLE;
         ERR:     if (tx_ready) parse_next = IDLE;
`ifdef UART_CMD_ECHO_EN
         ECHO:    if (tx_ready) parse_next = echo_ret;
`endif
         default: parse_next = IDLE;
      endcase

      state_next = parse_next;
`ifdef UART_CMD_ECHO_EN
      if (accept && !ignored)
         state_next = ECHO;
`endif
   end

   always_comb begin
      rx_ready = 1'b0;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      busy     = (state != IDLE);
      case (state)
         IDLE, CMD_HI, CMD_LO, WAIT_CR: rx_ready = rdy_en;
         // R never changes gpio_out, so the live register equals its value at CR.
         RESP0: begin
            tx_valid = 1'b1;
            tx_data  = (op == OP_R) ? nib2hex(gpio_out[7:4]) : CH_K;
         end
         RESP1: begin
            tx_valid = 1'b1;
            tx_data  = nib2hex(gpio_out[3:0]);
         end
         ERR: begin
            tx_valid = 1'b1;
            tx_data  = CH_ERR;
         end
`ifdef UART_CMD_ECHO_EN
         ECHO: begin
            tx_valid = 1'b1;
            tx_data  = echo_byte;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rdy_en    <= 1'b0;
         op        <= OP_W;
         operand   <= 8'h00;
         gpio_out  <= GPIO_RESET;
         err_count <= 8'h00;
      end else begin
         rdy_en <= 1'b1;
         if (accept) begin
            case (state)
               IDLE: begin
                  case (rx_data)
                     CH_S:    op <= OP_S;
                     CH_C:    op <= OP_C;
                     CH_R:    op <= OP_R;
                     default: op <= OP_W;
                  endcase
               end
               CMD_HI:  operand[7:4] <= hex2nib(rx_data);
               CMD_LO:  operand[3:0] <= hex2nib(rx_data);
               WAIT_CR: begin
                  if (rx_data == CH_CR) begin
                     case (op)
                        OP_W:    gpio_out <= operand;
                        OP_S:    gpio_out <= gpio_out | operand;
                        OP_C:    gpio_out <= gpio_out & ~operand;
                        default: ;
                     endcase
                  end
               end
               default: ;
            endcase
         end
         if ((state_next == ERR) && (state != ERR) && (err_count != 8'hFF))
            err_count <= err_count + 8'd1;
      end
   end

endmodule
